// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART boot loader.
package uart_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN0, ST_LEN1, ST_DATA, ST_WRITE, ST_CSUM, ST_DONE, ST_ERR
  } boot_state_e;

  typedef enum logic [1:0] {
    ERR_NONE, ERR_CSUM, ERR_LEN, ERR_LINK
  } boot_err_e;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK       = 8'h06;
  localparam logic [7:0] NAK       = 8'h15;

  // Bit period in clock cycles, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_boot_loader_rx.sv
// 8N1 byte receiver: synchroniser, mid-bit sampling, byte_vld / frame_err pulses.
module uart_rx_byte
  import uart_boot_pkg::*;
#(
  parameter int DIV = 217
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       frame_err_o
);

  localparam int CW   = $clog2(DIV);
  localparam int HALF = (DIV / 2 > 0) ? DIV / 2 : 1;

  rx_state_e     st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          sync1_q, sync2_q, prev_q;
  logic          vld_q, vld_d, ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'h00;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
    end
  end

  // A start is only taken on a falling edge, so a stuck-low line after a framing error is not re-read.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q + CW'(1);
    bit_d  = bit_q;
    sh_d   = sh_q;
    vld_d  = 1'b0;
    ferr_d = 1'b0;
    case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) st_d = RX_START;
        else                    st_d = RX_IDLE;
      end
      RX_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d = '0;
          bit_d = 3'd0;
          st_d  = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          st_d = RX_START;
        end
      end
      RX_DATA: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d = '0;
          sh_d  = {sync2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          st_d  = (bit_q == 3'd7) ? RX_STOP : RX_DATA;
        end else begin
          st_d = RX_DATA;
        end
      end
      RX_STOP: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d  = '0;
          vld_d  = sync2_q;
          ferr_d = !sync2_q;
          st_d   = RX_IDLE;
        end else begin
          st_d = RX_STOP;
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  assign byte_o      = sh_q;
  assign byte_vld_o  = vld_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_boot_loader.sv
// UART image loader: parses A5/LEN/data/CSUM frames and writes words to instruction memory.
// Optional status byte transmitter is enabled with the BOOT_LDR_ACK_EN macro.
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int BAUD        = 115_200,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int MAX_WORDS   = 4096,
  parameter int TIMEOUT_CYC = 16 * 10 * calc_div(CLK_FREQ_HZ, BAUD)
) (
  input  logic              sys_clk_i,
  input  logic              rst_n,
  input  logic              boot_sel_i,
  input  logic              uart_rx_i,
  output logic              uart_tx_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  output logic              cpu_rst_n_o,
  output logic              boot_done_o,
  output logic [1:0]        boot_err_o
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);
  localparam int BPW = DATA_W / 8;
  localparam int BCW = $clog2(BPW) + 1;
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);

  logic [7:0] rx_byte_s;
  logic       rx_vld_s, rx_ferr_s;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk         (sys_clk_i),
    .rst_n       (rst_n),
    .rx_i        (uart_rx_i),
    .byte_o      (rx_byte_s),
    .byte_vld_o  (rx_vld_s),
    .frame_err_o (rx_ferr_s)
  );

  boot_state_e       state_q, state_d;
  boot_err_e         err_q, err_d;
  logic [15:0]       len_q, len_d, wcnt_q, wcnt_d, len_full_s;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        csum_q, csum_d, buf_q, buf_d, in_byte_s, csum_next_s;
  logic              buf_vld_q, buf_vld_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [BCW-1:0]    bcnt_q, bcnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              mem_we_q, done_q, cpu_rst_q, cpu_rst_d;
  logic              take_s, active_s, tmo_hit_s, link_err_s, tx_start_s;
  logic [7:0]        tx_byte_s;

  always_ff @(posedge sys_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      err_q     <= ERR_NONE;
      len_q     <= 16'd0;
      wcnt_q    <= 16'd0;
      addr_q    <= '0;
      csum_q    <= 8'h00;
      buf_q     <= 8'h00;
      buf_vld_q <= 1'b0;
      asm_q     <= '0;
      bcnt_q    <= '0;
      tmo_q     <= '0;
      mem_we_q  <= 1'b0;
      done_q    <= 1'b0;
      cpu_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      len_q     <= len_d;
      wcnt_q    <= wcnt_d;
      addr_q    <= addr_d;
      csum_q    <= csum_d;
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
      asm_q     <= asm_d;
      bcnt_q    <= bcnt_d;
      tmo_q     <= tmo_d;
      mem_we_q  <= (state_d == ST_WRITE);
      done_q    <= (state_d == ST_DONE);
      cpu_rst_q <= cpu_rst_d;
    end
  end

  // The skid byte always has priority over a fresh receiver byte outside WRITE.
  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    len_d       = len_q;
    wcnt_d      = wcnt_q;
    addr_d      = addr_q;
    csum_d      = csum_q;
    asm_d       = asm_q;
    bcnt_d      = bcnt_q;
    buf_d       = buf_q;
    buf_vld_d   = buf_vld_q;
    tx_start_s  = 1'b0;
    tx_byte_s   = ACK;
    take_s      = (state_q != ST_WRITE) && (buf_vld_q || rx_vld_s);
    in_byte_s   = buf_vld_q ? buf_q : rx_byte_s;
    csum_next_s = csum_q + in_byte_s;
    len_full_s  = {in_byte_s, len_q[7:0]};
    active_s    = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                  (state_q == ST_DATA) || (state_q == ST_CSUM);
    tmo_hit_s   = active_s && !rx_vld_s && (tmo_q == TW'(TIMEOUT_CYC - 1));
    tmo_d       = (rx_vld_s || !active_s) ? '0 : tmo_q + TW'(1);
    link_err_s  = (active_s || state_q == ST_WRITE) &&
                  (rx_ferr_s || tmo_hit_s || (state_q == ST_WRITE && rx_vld_s && buf_vld_q));

    if (state_q == ST_WRITE) begin
      if (rx_vld_s && !buf_vld_q) begin
        buf_d     = rx_byte_s;
        buf_vld_d = 1'b1;
      end else begin
        buf_vld_d = buf_vld_q;
      end
    end else if (buf_vld_q) begin
      buf_d     = rx_byte_s;
      buf_vld_d = rx_vld_s;
    end else begin
      buf_vld_d = 1'b0;
    end

    if (link_err_s) begin
      state_d    = ST_ERR;
      err_d      = ERR_LINK;
      buf_vld_d  = 1'b0;
      tx_start_s = 1'b1;
      tx_byte_s  = NAK;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERR: begin
          if (state_q == ST_IDLE && !boot_sel_i) begin
            state_d = ST_DONE;
          end else if (take_s && in_byte_s == SYNC_BYTE) begin
            state_d = ST_LEN0;
            err_d   = ERR_NONE;
            wcnt_d  = 16'd0;
            addr_d  = '0;
            csum_d  = 8'h00;
            bcnt_d  = '0;
          end else begin
            state_d = state_q;
          end
        end
        ST_LEN0: begin
          if (take_s) begin
            len_d   = {8'h00, in_byte_s};
            csum_d  = csum_next_s;
            state_d = ST_LEN1;
          end else begin
            state_d = ST_LEN0;
          end
        end
        ST_LEN1: begin
          if (take_s) begin
            len_d  = len_full_s;
            csum_d = csum_next_s;
            if ({1'b0, len_full_s} > 17'(MAX_WORDS)) begin
              state_d    = ST_ERR;
              err_d      = ERR_LEN;
              tx_start_s = 1'b1;
              tx_byte_s  = NAK;
            end else if (len_full_s == 16'd0) begin
              state_d = ST_CSUM;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_LEN1;
          end
        end
        ST_DATA: begin
          if (take_s) begin
            asm_d  = {in_byte_s, asm_q[DATA_W-1:8]};
            csum_d = csum_next_s;
            if (bcnt_q == BCW'(BPW - 1)) begin
              bcnt_d  = '0;
              state_d = ST_WRITE;
            end else begin
              bcnt_d  = bcnt_q + BCW'(1);
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_WRITE: begin
          if (mem_ready_i) begin
            addr_d  = addr_q + ADDR_W'(1);
            wcnt_d  = wcnt_q + 16'd1;
            state_d = (wcnt_q + 16'd1 == len_q) ? ST_CSUM : ST_DATA;
          end else begin
            state_d = ST_WRITE;
          end
        end
        ST_CSUM: begin
          if (take_s) begin
            tx_start_s = 1'b1;
            if (csum_next_s == 8'h00) begin
              state_d   = ST_DONE;
              tx_byte_s = ACK;
            end else begin
              state_d   = ST_ERR;
              err_d     = ERR_CSUM;
              tx_byte_s = NAK;
            end
          end else begin
            state_d = ST_CSUM;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef BOOT_LDR_ACK_EN
  localparam int CW = $clog2(DIV);
  logic [9:0]    tx_sh_q, tx_sh_d;
  logic [3:0]    tx_bits_q, tx_bits_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          tx_line_q, tx_line_d;

  always_ff @(posedge sys_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh_q   <= 10'h3FF;
      tx_bits_q <= 4'd0;
      tx_cnt_q  <= '0;
      tx_line_q <= 1'b1;
    end else begin
      tx_sh_q   <= tx_sh_d;
      tx_bits_q <= tx_bits_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_line_q <= tx_line_d;
    end
  end

  // CPU reset release waits for the status byte's stop bit to finish.
  always_comb begin
    tx_sh_d   = tx_sh_q;
    tx_bits_d = tx_bits_q;
    tx_cnt_d  = tx_cnt_q;
    if (tx_start_s) begin
      tx_sh_d   = {1'b1, tx_byte_s, 1'b0};
      tx_bits_d = 4'd10;
      tx_cnt_d  = '0;
    end else if (tx_bits_q != 4'd0) begin
      if (tx_cnt_q == CW'(DIV - 1)) begin
        tx_cnt_d  = '0;
        tx_sh_d   = {1'b1, tx_sh_q[9:1]};
        tx_bits_d = tx_bits_q - 4'd1;
      end else begin
        tx_cnt_d = tx_cnt_q + CW'(1);
      end
    end else begin
      tx_cnt_d = '0;
    end
    tx_line_d = (tx_bits_d != 4'd0) ? tx_sh_d[0] : 1'b1;
    cpu_rst_d = (state_d == ST_DONE) && (tx_bits_d == 4'd0);
  end

  assign uart_tx_o = tx_line_q;
`else
  logic unused_tx_s;
  assign unused_tx_s = ^{tx_start_s, tx_byte_s};
  assign cpu_rst_d   = (state_d == ST_DONE);
  assign uart_tx_o   = 1'b1;
`endif

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = asm_q;
  assign cpu_rst_n_o = cpu_rst_q;
  assign boot_done_o = done_q;
  assign boot_err_o  = err_q;

endmodule
